// File: rtl/rr_arbiter4_if.sv
// Request/data/grant bundle between four requesters and the round-robin
// arbiter that owns the shared mux/decoder path.
interface rr_arbiter4_if;
  logic i_req_1, i_req_2, i_req_3, i_req_4;
  logic i_d_1, i_d_2, i_d_3, i_d_4;
  logic o_gnt_1, o_gnt_2, o_gnt_3, o_gnt_4;
  logic o_s_1, o_s_2;
  logic o_busy;
  logic o;

  // Requester side: raises requests, supplies data, observes grants.
  modport master (
    output i_req_1, i_req_2, i_req_3, i_req_4,
    output i_d_1, i_d_2, i_d_3, i_d_4,
    input  o_gnt_1, o_gnt_2, o_gnt_3, o_gnt_4,
    input  o_s_1, o_s_2, o_busy, o
  );

  // Arbiter side.
  modport slave (
    input  i_req_1, i_req_2, i_req_3, i_req_4,
    input  i_d_1, i_d_2, i_d_3, i_d_4,
    output o_gnt_1, o_gnt_2, o_gnt_3, o_gnt_4,
    output o_s_1, o_s_2, o_busy, o
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded hold time. Grants are registered
// and one-hot; every change of owner passes through one idle cycle.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic       clk,
  input logic       rst,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Last hold-count value before the owner must yield (or renew).
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel, sel_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic [3:0] gnt, gnt_nxt;
  logic       busy, busy_nxt;

  logic [3:0] req;
  logic [3:0] dat;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;
  logic       own_req;
  logic       other_req;

  assign req = {bus.i_req_4, bus.i_req_3, bus.i_req_2, bus.i_req_1};
  assign dat = {bus.i_d_4, bus.i_d_3, bus.i_d_2, bus.i_d_1};

  // Rotating-priority search: first active request at or after ptr.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign own_req   = req[sel];
  assign other_req = |(req & ~(4'b0001 << sel));

  // Next-state and registered-output computation.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    hcnt_nxt  = hcnt;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win;
          sel_nxt   = win;
          busy_nxt  = 1'b1;
          hcnt_nxt  = 8'd0;
          ptr_nxt   = win + 2'd1;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Owner released: drop grant, keep select for the turnaround.
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          busy_nxt  = 1'b0;
        end else if (hcnt == HOLD_LAST) begin
          if (other_req) begin
            // Hold budget spent and someone is waiting: force a turnaround.
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
          end else begin
            // Nobody else wants the path: renew without a gap.
            hcnt_nxt = 8'd0;
          end
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      hcnt  <= 8'd0;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      hcnt  <= hcnt_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
    end
  end

  assign bus.o_gnt_1 = gnt[0];
  assign bus.o_gnt_2 = gnt[1];
  assign bus.o_gnt_3 = gnt[2];
  assign bus.o_gnt_4 = gnt[3];
  assign bus.o_s_1   = sel[1];
  assign bus.o_s_2   = sel[0];
  assign bus.o_busy  = busy;
  assign bus.o       = busy & dat[sel];

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_arbiter4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  wire [3:0] gv = {bus.o_gnt_4, bus.o_gnt_3, bus.o_gnt_2, bus.o_gnt_1};
  wire [1:0] sv = {bus.o_s_1, bus.o_s_2};
  wire [3:0] rv = {bus.i_req_4, bus.i_req_3, bus.i_req_2, bus.i_req_1};
  wire [3:0] dv = {bus.i_d_4, bus.i_d_3, bus.i_d_2, bus.i_d_1};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    bus.i_req_1 = r[0];
    bus.i_req_2 = r[1];
    bus.i_req_3 = r[2];
    bus.i_req_4 = r[3];
  endtask

  task automatic set_d(input logic [3:0] d);
    bus.i_d_1 = d[0];
    bus.i_d_2 = d[1];
    bus.i_d_3 = d[2];
    bus.i_d_4 = d[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: who owns the path, how long they have held it in the
  // current run, and whose turn is next.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_run   = 0;
  int         m_sel   = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_r;
  logic       m_rs;
  bit         m_others;
  int         m_c;
  logic [3:0] e_g;
  logic       e_o;

  always @(posedge clk) begin
    m_r  = rv;
    m_rs = rst;
    if (m_rs) begin
      m_valid = 1'b1;
      m_owner = -1;
      m_ptr   = 0;
      m_run   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        m_c = (m_ptr + i) % 4;
        if (m_owner < 0 && m_r[m_c]) m_owner = m_c;
      end
      if (m_owner >= 0) begin
        m_sel = m_owner;
        m_ptr = (m_owner + 1) % 4;
        m_run = 1;
      end
    end else begin
      m_others = 1'b0;
      for (int i = 0; i < 4; i++)
        if (i != m_owner && m_r[i]) m_others = 1'b1;
      if (!m_r[m_owner]) m_owner = -1;
      else if (m_run == MH) begin
        if (m_others) m_owner = -1;
        else m_run = 1;
      end else m_run = m_run + 1;
    end
    #1;
    if (m_valid) begin
      e_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_o = (m_owner >= 0) ? dv[m_owner] : 1'b0;
      check("model_gnt", {4'd0, gv}, {4'd0, e_g});
      check("model_sel", {6'd0, sv}, 8'(m_sel));
      check("model_busy", {7'd0, bus.o_busy}, {7'd0, (m_owner >= 0)});
      check("model_o", {7'd0, bus.o}, {7'd0, e_o});
    end
  end

  initial begin
    rst = 1'b1;
    set_req(4'b1111);
    set_d(4'b0000);

    // Reset held two cycles with every request high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_gnt", {4'd0, gv}, 8'h00);
      check("rst_sel", {6'd0, sv}, 8'h00);
      check("rst_busy", {7'd0, bus.o_busy}, 8'h00);
    end
    rst = 1'b0;
    tick();
    check("post_rst_gnt1", {4'd0, gv}, 8'h01);

    // Lone requester 3 with toggling data.
    set_req(4'b0100);
    tick();
    check("t2_release1", {4'd0, gv}, 8'h00);
    tick();
    check("t2_gnt3", {4'd0, gv}, 8'h04);
    check("t2_sel", {6'd0, sv}, 8'h02);
    for (int i = 0; i < 4; i++) begin
      bus.i_d_3 = i[0];
      #1;
      check("t2_o_track", {7'd0, bus.o}, {7'd0, i[0]});
      tick();
      check("t2_gnt3_hold", {4'd0, gv}, 8'h04);
    end
    set_req(4'b0000);
    tick();
    check("t2_drop", {4'd0, gv}, 8'h00);

    // Full contention from a fresh pointer: 1,2,3,4,1, each MH cycles + gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(4'b1111);
    for (int c = 1; c <= 25; c++) begin
      tick();
      check("t3_rotate", {4'd0, gv},
            (c % 5 == 0) ? 8'h00 : 8'(1 << (((c - 1) / 5) % 4)));
    end

    // Single continuous requester renews with no gap.
    set_req(4'b0010);
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t4_no_gap", {4'd0, gv}, 8'h02);
    end
    set_req(4'b0000);
    tick();
    check("t4_drop", {4'd0, gv}, 8'h00);

    // Pointer skips idle requesters; returning requester 1 wins after 4.
    set_req(4'b0001);
    tick();
    check("t5_gnt1", {4'd0, gv}, 8'h01);
    set_req(4'b1001);
    tick();
    check("t5_gnt1_hold", {4'd0, gv}, 8'h01);
    set_req(4'b1000);
    tick();
    check("t5_turnaround", {4'd0, gv}, 8'h00);
    tick();
    check("t5_gnt4", {4'd0, gv}, 8'h08);
    set_req(4'b1001);
    tick();
    check("t5_gnt4_hold", {4'd0, gv}, 8'h08);
    set_req(4'b0001);
    tick();
    check("t5_gap", {4'd0, gv}, 8'h00);
    tick();
    check("t5_gnt1_again", {4'd0, gv}, 8'h01);
    set_req(4'b0000);
    tick();

    // Reset in the middle of a grant to requester 3.
    set_d(4'b1111);
    set_req(4'b0100);
    tick();
    check("t6_gnt3", {4'd0, gv}, 8'h04);
    set_req(4'b1111);
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_gnt", {4'd0, gv}, 8'h00);
    check("t6_rst_sel", {6'd0, sv}, 8'h00);
    check("t6_rst_busy", {7'd0, bus.o_busy}, 8'h00);
    check("t6_rst_o", {7'd0, bus.o}, 8'h00);
    rst = 1'b0;
    tick();
    check("t6_gnt1", {4'd0, gv}, 8'h01);

    // Randomized traffic, sticky requests, rare resets.
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] r;
      r = rv;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      set_req(r);
      set_d(4'($urandom_range(0, 15)));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
